exe_mem_wb_pipe: RTL and testbench

Back end of the 5-stage MIPS pipeline. Consumes the ID/EXE pipeline register outputs, executes the ALU operation, accesses data memory, and drives the register-file write port. Contains the EXE/MEM and MEM/WB pipeline registers, the data memory, the writeback mux and a retired-write counter.

---
 rtl/exe_mem_wb_pipe_if.sv | 31 +++
 rtl/exe_mem_wb_pipe.sv | 117 +++++++++++
 tb/tb_exe_mem_wb_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_wb_pipe_if.sv
// Bundle of the ID/EXE-side inputs and the forwarding/writeback outputs of the MIPS back end.
// The master side (decode/issue) drives the e* fields and the slave side (the back end) returns the m*/wb_* results.
interface exe_mem_wb_pipe_if;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic [4:0]  emux;
  logic [31:0] eqa;
  logic [31:0] eqb;
  logic [31:0] eimm;

  logic        mwreg;
  logic [4:0]  mmux;
  logic [31:0] malu;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  modport master (
    output ewreg, em2reg, ewmem, ealuc, ealuimm, emux, eqa, eqb, eimm,
    input  mwreg, mmux, malu, wb_we, wb_addr, wb_data, retire_cnt
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ealuc, ealuimm, emux, eqa, eqb, eimm,
    output mwreg, mmux, malu, wb_we, wb_addr, wb_data, retire_cnt
  );
endinterface

// File: rtl/exe_mem_wb_pipe.sv
// EXE, MEM and WB stages of a 5-stage MIPS pipeline: ALU, EXE/MEM and MEM/WB registers,
// word-addressed data memory, the writeback mux and a counter of retired register writes.
module exe_mem_wb_pipe #(
  parameter int DMEM_DEPTH = 512,
  parameter int DMEM_AW    = 9
) (
  input logic              clk,
  input logic              rst,
  exe_mem_wb_pipe_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [31:0] alu_b;
  logic [31:0] alu_y;

  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mmux;
  logic [31:0] malu, mqb;

  logic        wwreg, wm2reg;
  logic [4:0]  wmux;
  logic [31:0] walu, wdo;

  logic [31:0] mem_rdata;
  logic [31:0] retire_cnt;
  logic        wb_we;

  // NOTE: the data memory has no reset; its power-up image comes from the declaration
  // initializer, and a reset must leave stored data intact.
  logic [31:0] mem [DMEM_DEPTH] = '{0: 32'hA00000AA, 1: 32'h10000011,
                                    2: 32'h20000022, 3: 32'h30000033,
                                    default: 32'h0};

  logic [DMEM_AW-1:0] mem_idx;
  logic               unused_addr_bits;

  always_comb begin
    alu_b = bus.ealuimm ? bus.eimm : bus.eqb;
    alu_y = '0;
    case (bus.ealuc)
      ALU_ADD: alu_y = bus.eqa + alu_b;
      ALU_SUB: alu_y = bus.eqa - alu_b;
      ALU_AND: alu_y = bus.eqa & alu_b;
      ALU_OR:  alu_y = bus.eqa | alu_b;
      ALU_SLT: alu_y = {31'b0, $signed(bus.eqa) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  // NOTE: all pipeline state uses non-blocking assignments so every stage samples the
  // previous stage's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mmux   <= '0;
      malu   <= '0;
      mqb    <= '0;
    end else begin
      mwreg  <= bus.ewreg;
      mm2reg <= bus.em2reg;
      mwmem  <= bus.ewmem;
      mmux   <= bus.emux;
      malu   <= alu_y;
      mqb    <= bus.eqb;
    end
  end

  // Byte offset and bits above the memory size are dropped, so addresses wrap.
  assign mem_idx          = malu[DMEM_AW+1:2];
  assign unused_addr_bits = ^{malu[31:DMEM_AW+2], malu[1:0]};
  assign mem_rdata        = mem[mem_idx];

  // mwmem is held at 0 by reset, so no store can land while rst is asserted.
  always_ff @(posedge clk) begin
    if (mwmem) mem[mem_idx] <= mqb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmux   <= '0;
      walu   <= '0;
      wdo    <= '0;
    end else begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      wmux   <= mmux;
      walu   <= malu;
      wdo    <= mem_rdata;
    end
  end

  // Register $0 is hardwired to zero, so writes to it never retire.
  assign wb_we = wwreg && (wmux != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retire_cnt <= '0;
    else if (wb_we) retire_cnt <= retire_cnt + 32'd1;
  end

  assign bus.mwreg      = mwreg;
  assign bus.mmux       = mmux;
  assign bus.malu       = malu;
  assign bus.wb_we      = wb_we;
  assign bus.wb_addr    = wmux;
  assign bus.wb_data    = wm2reg ? wdo : walu;
  assign bus.retire_cnt = retire_cnt;

endmodule

// File: tb/tb_exe_mem_wb_pipe.sv
// Scoreboard bench for exe_mem_wb_pipe: directed MIPS sequences plus random traffic, checked
// against a program-order instruction model with its own copy of data memory.
module tb_exe_mem_wb_pipe;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  exe_mem_wb_pipe_if bus ();

  exe_mem_wb_pipe #(.DMEM_DEPTH(DEPTH), .DMEM_AW(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        wreg;
    logic [4:0]  mux;
    logic [31:0] alu;
  } fwd_t;

  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  fwd_t        fwd_q[$];
  wb_t         wb_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_retire = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [3:0] op, input logic aluimm, input logic [4:0] rd,
                       input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm);
    bus.ewreg   = wreg;
    bus.em2reg  = m2reg;
    bus.ewmem   = wmem;
    bus.ealuc   = op;
    bus.ealuimm = aluimm;
    bus.emux    = rd;
    bus.eqa     = qa;
    bus.eqb     = qb;
    bus.eimm    = imm;
  endtask

  // One instruction per cycle; the model executes it completely at issue time, in program order.
  task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [3:0] op, input logic aluimm, input logic [4:0] rd,
                       input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm);
    logic [31:0] res;
    int          idx;
    wb_t         w;
    fwd_t        f;
    @(negedge clk);
    drive(wreg, m2reg, wmem, op, aluimm, rd, qa, qb, imm);
    res    = ref_alu(op, qa, aluimm ? imm : qb);
    idx    = int'((res / 4) % DEPTH);
    f.due  = cyc + 1;
    f.wreg = wreg;
    f.mux  = rd;
    f.alu  = res;
    fwd_q.push_back(f);
    w.due  = cyc + 2;
    w.we   = wreg && (rd != 0);
    w.addr = rd;
    w.data = m2reg ? ref_mem[idx] : res;
    wb_q.push_back(w);
    if (wmem) ref_mem[idx] = qb;
  endtask

  task automatic bubble();
    issue(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [31:0] base, input logic [31:0] off);
    issue(1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, rd, base, 32'd0, off);
  endtask

  task automatic sw(input logic [31:0] base, input logic [31:0] off, input logic [31:0] data);
    issue(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 5'd0, base, data, off);
  endtask

  task automatic rtype(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b);
    issue(1'b1, 1'b0, 1'b0, op, 1'b0, rd, a, b, 32'h5555_5555);
  endtask

  // Monitor: compares whatever the pipeline presents against the entries due this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (fwd_q.size() > 0 && fwd_q[0].due == cyc) begin
        fwd_t f;
        f = fwd_q.pop_front();
        check("mwreg", 32'(bus.mwreg), 32'(f.wreg));
        check("mmux",  32'(bus.mmux),  32'(f.mux));
        check("malu",  bus.malu,       f.alu);
      end
      if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
        wb_t w;
        w = wb_q.pop_front();
        check("wb_we", 32'(bus.wb_we), 32'(w.we));
        check("retire_cnt", bus.retire_cnt, exp_retire);
        if (w.we) begin
          check("wb_addr", 32'(bus.wb_addr), 32'(w.addr));
          check("wb_data", bus.wb_data, w.data);
          exp_retire = exp_retire + 1;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " mwreg"},      32'(bus.mwreg),   32'd0);
    check({tag, " mmux"},       32'(bus.mmux),    32'd0);
    check({tag, " malu"},       bus.malu,         32'd0);
    check({tag, " wb_we"},      32'(bus.wb_we),   32'd0);
    check({tag, " wb_addr"},    32'(bus.wb_addr), 32'd0);
    check({tag, " wb_data"},    bus.wb_data,      32'd0);
    check({tag, " retire_cnt"}, bus.retire_cnt,   32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    int          kind;
    logic [31:0] base;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    ref_mem[0] = 32'hA00000AA;
    ref_mem[1] = 32'h10000011;
    ref_mem[2] = 32'h20000022;
    ref_mem[3] = 32'h30000033;

    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Loads of the preset words, back to back.
    lw(5'd2, 32'd0, 32'd0);
    lw(5'd3, 32'd0, 32'd4);
    bubble();
    // Store then immediate load of the same word.
    sw(32'd8, 32'd4, 32'hDEADBEEF);
    lw(5'd5, 32'd12, 32'd0);
    // R-type ALU codes including an undefined one.
    rtype(4'b0110, 5'd4, 32'd5, 32'd7);
    rtype(4'b0111, 5'd4, 32'd5, 32'd7);
    rtype(4'b0000, 5'd4, 32'd5, 32'd7);
    rtype(4'b0001, 5'd4, 32'd5, 32'd7);
    rtype(4'b1111, 5'd4, 32'd5, 32'd7);
    rtype(4'b0111, 5'd6, 32'hFFFF_FFFF, 32'd1);
    rtype(4'b0010, 5'd7, 32'hFFFF_FFFF, 32'd2);
    // Write to $0 must not retire.
    rtype(4'b0010, 5'd0, 32'd1, 32'd2);
    // Address wrap: word 512+1 aliases word 1; low byte bits ignored.
    lw(5'd8, 32'h0000_0804, 32'd0);
    lw(5'd9, 32'd7, 32'd0);

    // Random mix of loads, stores, R-type, I-type and bubbles.
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 4));
      base = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31) * 4);
      case (kind)
        0: lw(5'($urandom), base, 32'($urandom_range(0, 3)));
        1: sw(base, 32'($urandom_range(0, 3)), $urandom);
        2: rtype(4'($urandom), 5'($urandom), $urandom, $urandom);
        3: issue(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 5'($urandom), $urandom, $urandom,
                 {{16{1'b1}}, 16'($urandom)});
        default: bubble();
      endcase
    end

    // Reset with a store and a load in flight: store must be squashed.
    bubble();
    bubble();
    bubble();
    saved = ref_mem[10];
    sw(32'd40, 32'd0, 32'hCAFEF00D);
    lw(5'd6, 32'd40, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    fwd_q.delete();
    wb_q.delete();
    ref_mem[10] = saved;
    exp_retire  = 0;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_all_zero("in reset");
    @(negedge clk);
    rst = 1'b0;
    lw(5'd10, 32'd40, 32'd0);
    lw(5'd11, 32'd0, 32'd0);
    bubble();
    bubble();

    for (int t = 0; t < 40 && (wb_q.size() > 0 || fwd_q.size() > 0); t++) @(negedge clk);
    if (wb_q.size() > 0 || fwd_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results still pending, expected 0", wb_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
